// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns load/store control into a word-wide
// request/acknowledge bus transaction and returns aligned, extended load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lo_q, lo_d;

  logic        access_s;
  logic        addr_err_s;
  logic [31:0] load_s;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                               input logic [1:0] lo, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign access_s   = mem_read | mem_write;
  assign addr_err_s = access_s & ((mem_size == 2'b11) |
                                  ((mem_size == 2'b01) & addr[0]) |
                                  ((mem_size == 2'b10) & (addr[1:0] != 2'b00)));
  // Extraction uses the fields latched at issue, not the live instruction inputs.
  assign load_s     = load_extract(size_q, uns_q, lo_q, bus_rdata);

  assign stall     = ~rst & access_s & ~addr_err_s & (state_q != DONE);
  assign addr_err  = ~rst & addr_err_s;
  assign rdata     = rdata_q;
  assign bus_err   = err_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    size_d  = size_q;
    uns_d   = uns_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (access_s && !addr_err_s) begin
          state_d = REQ;
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = store_be(mem_size, addr[1:0]);
          wdata_d = store_data(mem_size, wdata);
          size_d  = mem_size;
          uns_d   = mem_unsigned;
          lo_d    = addr[1:0];
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // An ack in the same cycle as the timeout wins.
        if (bus_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = load_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if ((cnt_q + 8'd1) == TIMEOUT_L) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      lo_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected bus/retire results are queued
// at issue and compared while the bus cycle runs and when the instruction retires.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
  logic        stall, addr_err, bus_err, bus_req, bus_we, bus_ack;
  logic [3:0]  bus_be;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rdata = 32'd0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        aerr;
    int          stalls;
    int          reqs;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwdata;
  } exp_t;

  exp_t exp_q[$];

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .addr_err(addr_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one instruction (called just after a rising edge); ack_wait < 0 means never ack.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rw, input int ack_wait);
    exp_t e;
    exp_t h;
    int nb, lo, stall_n, req_n;
    logic [31:0] sh, v;
    logic done;
    lo = int'(a[1:0]);
    nb = (sz == 2'b11) ? 0 : (1 << sz);
    e.aerr = (sz == 2'b11) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
    e.we = wr;
    e.baddr = a & 32'hFFFF_FFFC;
    e.be = 4'd0;
    e.bwdata = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (nb != 0) begin
        e.bwdata[8*k +: 8] = wd[8*(k % nb) +: 8];
        if (k >= lo && k < lo + nb) e.be[k] = 1'b1;
      end
    end
    sh = rw >> (8 * lo);
    if (nb == 1)      v = uns ? (sh & 32'hFF)   : {{24{sh[7]}}, sh[7:0]};
    else if (nb == 2) v = uns ? (sh & 32'hFFFF) : {{16{sh[15]}}, sh[15:0]};
    else              v = rw;
    e.err = 1'b0;
    if (e.aerr) begin
      e.stalls = 0; e.reqs = 0;
    end else if (ack_wait < 0) begin
      e.stalls = T + 1; e.reqs = T; e.err = 1'b1; model_rdata = 32'd0;
    end else begin
      e.stalls = ack_wait + 2; e.reqs = ack_wait + 1;
      if (!wr) model_rdata = v;
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);

    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
    stall_n = 0; req_n = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (bus_req) begin
        req_n++;
        if (exp_q.size() > 0) begin
          h = exp_q[0];
          check_eq("bus_we", {31'd0, bus_we}, {31'd0, h.we});
          check_eq("bus_addr", bus_addr, h.baddr);
          check_eq("bus_be", {28'd0, bus_be}, {28'd0, h.be});
          check_eq("bus_wdata", bus_wdata, h.bwdata);
        end
        bus_ack = (ack_wait >= 0) && (req_n == ack_wait + 1);
        bus_rdata = rw;
      end else begin
        bus_ack = 1'b0;
      end
      if (!stall) begin
        done = 1'b1;
        h = exp_q.pop_front();
        check_eq("rdata", rdata, h.rdata);
        check_eq("bus_err", {31'd0, bus_err}, {31'd0, h.err});
        check_eq("addr_err", {31'd0, addr_err}, {31'd0, h.aerr});
        check_eq("stall_cycles", stall_n, h.stalls);
        check_eq("req_cycles", req_n, h.reqs);
      end
    end
    check_eq("retire_bound", {31'd0, done}, 32'd1);
    if (!done && exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    check_eq("err_pulse_end", {31'd0, bus_err}, 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
    mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b11; mem_unsigned = 1'b0;
    addr = 32'h3; wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_req", {31'd0, bus_req}, 32'd0);
    check_eq("rst_we", {31'd0, bus_we}, 32'd0);
    check_eq("rst_addr", bus_addr, 32'd0);
    check_eq("rst_be", {28'd0, bus_be}, 32'd0);
    check_eq("rst_wdata", bus_wdata, 32'd0);
    check_eq("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_addr_err", {31'd0, addr_err}, 32'd0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'h80FF7F01, 0);
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'h80FF7F01, 0);
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'd0, 3);
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 32'd0, 0);
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h05, 32'd0, 32'd0, 0);
    do_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h08, 32'd0, 32'd0, 0);
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'd0, -1);
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h42, 32'd0, 32'h8001_7FFE, 1);
    do_access(1'b1, 1'b1, 2'b00, 1'b0, 32'h51, 32'h0000_00A5, 32'hFFFF_FFFF, 0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      do_access(1'(i % 2), 1'((i + 1) % 2), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                ra, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    // Reset arrives in the second REQ cycle; the ack after it must be ignored.
    mem_read = 1'b1; mem_size = 2'b10; addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("rstx_req_before", {31'd0, bus_req}, 32'd1);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    check_eq("rstx_req_after", {31'd0, bus_req}, 32'd0);
    check_eq("rstx_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus_ack = 1'b0;
    check_eq("rstx_late_req", {31'd0, bus_req}, 32'd0);
    check_eq("rstx_rdata", rdata, 32'd0);
    check_eq("rstx_bus_err", {31'd0, bus_err}, 32'd0);
    model_rdata = 32'd0;
    @(posedge clk); #1;

    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 32'd0, 0);
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'hCAFEF00D, 0);
    check_eq("b2b_load", rdata, 32'hCAFEF00D);
    @(negedge clk);
    check_eq("b2b_idle_req", {31'd0, bus_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
